// File: rtl/axi_b_resp_allocator.sv
// B-channel merger: round-robin over init ports, outstanding counter, DECERR queue.
// Define AXI_B_OUT_REG_EN for a one-entry output register (1-cycle latency).
module axi_b_resp_allocator #(
    parameter int AXI_USER_W  = 6,
    parameter int N_INIT_PORT = 4,
    parameter int N_TARG_PORT = 7,
    parameter int AXI_ID_IN   = 16,
    parameter int AXI_ID_OUT  = AXI_ID_IN + $clog2(N_TARG_PORT),
    parameter int CNT_W       = 10,
    parameter int ERR_DEPTH   = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [N_INIT_PORT*AXI_ID_OUT-1:0] bid_i,
    input  logic [N_INIT_PORT*2-1:0]          bresp_i,
    input  logic [N_INIT_PORT*AXI_USER_W-1:0] buser_i,
    input  logic [N_INIT_PORT-1:0]            bvalid_i,
    output logic [N_INIT_PORT-1:0]            bready_o,
    output logic [AXI_ID_IN-1:0]              bid_o,
    output logic [1:0]                        bresp_o,
    output logic [AXI_USER_W-1:0]             buser_o,
    output logic                              bvalid_o,
    input  logic                              bready_i,
    input  logic                              incr_req_i,
    output logic                              full_counter_o,
    output logic                              outstanding_trans_o,
    input  logic                              err_push_i,
    input  logic [AXI_ID_IN-1:0]              err_id_i,
    input  logic [AXI_USER_W-1:0]             err_user_i,
    output logic                              err_full_o,
    output logic                              err_pending_o
);
    localparam int PW = (N_INIT_PORT > 1) ? $clog2(N_INIT_PORT) : 1;
    localparam int AW = $clog2(ERR_DEPTH);
    localparam logic [PW-1:0] LAST = PW'(N_INIT_PORT - 1);

    typedef enum logic {ARB, ERR} state_t;
    state_t state_q, state_d;

    logic [PW-1:0]         rr_q, lock_idx_q, pick, sel;
    logic                  lock_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [AXI_ID_IN-1:0]  fid [ERR_DEPTH];
    logic [AXI_USER_W-1:0] fuser [ERR_DEPTH];
    logic [AW:0]           wr_q, rd_q;
    logic                  f_full, f_empty, push, pop;
    logic                  any_valid, real_hs, stall, err_ok, go_err;
    logic [AXI_ID_IN-1:0]  mux_id;
    logic [1:0]            mux_resp;
    logic [AXI_USER_W-1:0] mux_user;
    logic [AXI_ID_IN-1:0]  head_id;
    logic [AXI_USER_W-1:0] head_user;

    // first valid port at or after the pointer
    always_comb begin
        int j;
        logic [PW-1:0] idx;
        pick = rr_q;
        for (int k = N_INIT_PORT - 1; k >= 0; k--) begin
            j = int'(rr_q) + k;
            if (j >= N_INIT_PORT) j = j - N_INIT_PORT;
            idx = PW'(j);
            if (bvalid_i[idx]) pick = idx;
        end
    end

    assign any_valid = |bvalid_i;
    assign sel       = lock_q ? lock_idx_q : pick;
    assign mux_id    = bid_i[int'(sel)*AXI_ID_OUT +: AXI_ID_IN];
    assign mux_resp  = bresp_i[int'(sel)*2 +: 2];
    assign mux_user  = buser_i[int'(sel)*AXI_USER_W +: AXI_USER_W];

    assign f_empty   = (wr_q == rd_q);
    assign f_full    = (wr_q[AW] != rd_q[AW]) &&
                       (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign head_id   = fid[rd_q[AW-1:0]];
    assign head_user = fuser[rd_q[AW-1:0]];
    assign push      = err_push_i && (!f_full || pop);

    assign err_ok = (state_q == ARB) && !f_empty && (cnt_q == '0) &&
                    !any_valid && !lock_q;

`ifdef AXI_B_OUT_REG_EN
    logic                  ov_q, load_en;
    logic [AXI_ID_IN-1:0]  oid_q;
    logic [1:0]            oresp_q;
    logic [AXI_USER_W-1:0] ouser_q;

    assign load_en = !ov_q || bready_i;
    assign real_hs = (state_q == ARB) && any_valid && load_en;
    assign stall   = (state_q == ARB) && any_valid && !load_en;
    assign pop     = (state_q == ERR) && load_en;
    assign go_err  = err_ok && !ov_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ov_q    <= 1'b0;
            oid_q   <= '0;
            oresp_q <= '0;
            ouser_q <= '0;
        end else if (load_en) begin
            if (state_q == ERR) begin
                ov_q    <= 1'b1;
                oid_q   <= head_id;
                oresp_q <= 2'b11;
                ouser_q <= head_user;
            end else begin
                ov_q    <= any_valid;
                oid_q   <= mux_id;
                oresp_q <= mux_resp;
                ouser_q <= mux_user;
            end
        end
    end

    always_comb begin
        bready_o = '0;
        if (rst_n && state_q == ARB && any_valid) bready_o[sel] = load_en;
        bvalid_o = ov_q;
        bid_o    = oid_q;
        bresp_o  = oresp_q;
        buser_o  = ouser_q;
    end
`else
    assign real_hs = (state_q == ARB) && any_valid && bready_i;
    assign stall   = (state_q == ARB) && any_valid && !bready_i;
    assign pop     = (state_q == ERR) && bready_i;
    assign go_err  = err_ok;

    always_comb begin
        bready_o = '0;
        bvalid_o = 1'b0;
        bid_o    = '0;
        bresp_o  = '0;
        buser_o  = '0;
        if (rst_n) begin
            if (state_q == ERR) begin
                bvalid_o = 1'b1;
                bid_o    = head_id;
                bresp_o  = 2'b11;
                buser_o  = head_user;
            end else begin
                bvalid_o = any_valid;
                bid_o    = mux_id;
                bresp_o  = mux_resp;
                buser_o  = mux_user;
                if (any_valid) bready_o[sel] = bready_i;
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB: if (go_err) state_d = ERR;
            ERR: if (pop) state_d = ARB;
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB;
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            cnt_q      <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
        end else begin
            state_q <= state_d;
            lock_q  <= stall;
            if (stall) lock_idx_q <= sel;
            if (real_hs) rr_q <= (sel == LAST) ? '0 : sel + PW'(1);
            if (incr_req_i && !real_hs && cnt_q != '1)
                cnt_q <= cnt_q + CNT_W'(1);
            else if (real_hs && !incr_req_i && cnt_q != '0)
                cnt_q <= cnt_q - CNT_W'(1);
            if (push) wr_q <= wr_q + (AW+1)'(1);
            if (pop) rd_q <= rd_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fid[wr_q[AW-1:0]]   <= err_id_i;
            fuser[wr_q[AW-1:0]] <= err_user_i;
        end
    end

    assign full_counter_o      = rst_n && (cnt_q == '1);
    assign outstanding_trans_o = rst_n && (cnt_q != '0);
    assign err_full_o          = rst_n && f_full;
    assign err_pending_o       = rst_n && !f_empty;

endmodule

// File: tb/tb_axi_b_resp_allocator.sv
// Directed bench for axi_b_resp_allocator (default build, 4 init ports).
module tb_axi_b_resp_allocator;
    localparam int N   = 4;
    localparam int IDI = 16;
    localparam int IDO = 19;
    localparam int UW  = 6;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N*IDO-1:0] bid_i;
    logic [N*2-1:0] bresp_i;
    logic [N*UW-1:0] buser_i;
    logic [N-1:0]   bvalid_i;
    logic [N-1:0]   bready_o;
    logic [IDI-1:0] bid_o;
    logic [1:0]     bresp_o;
    logic [UW-1:0]  buser_o;
    logic           bvalid_o;
    logic           bready_i;
    logic           incr_req_i;
    logic           full_counter_o;
    logic           outstanding_trans_o;
    logic           err_push_i;
    logic [IDI-1:0] err_id_i;
    logic [UW-1:0]  err_user_i;
    logic           err_full_o;
    logic           err_pending_o;

    axi_b_resp_allocator dut (
        .clk(clk), .rst_n(rst_n),
        .bid_i(bid_i), .bresp_i(bresp_i), .buser_i(buser_i),
        .bvalid_i(bvalid_i), .bready_o(bready_o),
        .bid_o(bid_o), .bresp_o(bresp_o), .buser_o(buser_o),
        .bvalid_o(bvalid_o), .bready_i(bready_i),
        .incr_req_i(incr_req_i), .full_counter_o(full_counter_o),
        .outstanding_trans_o(outstanding_trans_o),
        .err_push_i(err_push_i), .err_id_i(err_id_i),
        .err_user_i(err_user_i), .err_full_o(err_full_o),
        .err_pending_o(err_pending_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    int          n_err;
    logic [15:0] err_ids [8];
    logic [5:0]  err_usr [8];

    initial begin
        for (int p = 0; p < N; p++) begin
            bid_i[p*IDO +: IDO]  = {3'b101, 16'hA000 + 16'(p)};
            bresp_i[p*2 +: 2]    = 2'(p);
            buser_i[p*UW +: UW]  = 6'(p + 8);
        end
        bvalid_i   = 4'b1111;
        bready_i   = 1'b1;
        incr_req_i = 1'b0;
        err_push_i = 1'b0;
        err_id_i   = '0;
        err_user_i = '0;

        step;
        step;
        chk("rst_bvalid", 32'(bvalid_o), 32'd0);
        chk("rst_bready", 32'(bready_o), 32'd0);
        chk("rst_bid", 32'(bid_o), 32'd0);
        chk("rst_outst", 32'(outstanding_trans_o), 32'd0);
        chk("rst_pend", 32'(err_pending_o), 32'd0);
        rst_n = 1'b1;
        #1;

        // round robin 0,1,2,3,0 with routing bits stripped
        for (int k = 0; k < 5; k++) begin
            chk("rr_bid", 32'(bid_o), 32'hA000 + 32'(k % 4));
            chk("rr_bready", 32'(bready_o), 32'(1 << (k % 4)));
            chk("rr_user", 32'(buser_o), 32'(k % 4 + 8));
            step;
        end
        chk("dec_at_zero", 32'(outstanding_trans_o), 32'd0);

        // lock: pointer is 1, only port 2 valid, then ports 0,1 rise
        bvalid_i = 4'b0100;
        bready_i = 1'b0;
        #1;
        chk("lock_first", 32'(bid_o), 32'hA002);
        step;
        bvalid_i = 4'b0111;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("lock_hold", 32'(bid_o), 32'hA002);
            step;
        end
        bready_i = 1'b1;
        #1;
        chk("lock_bready", 32'(bready_o), 32'b0100);
        step;
        bvalid_i = 4'b0011;
        #1;
        chk("lock_next", 32'(bid_o), 32'hA000);
        bvalid_i = 4'b0000;

        // counter saturation
        incr_req_i = 1'b1;
        repeat (1022) step;
        chk("cnt_1022", 32'(full_counter_o), 32'd0);
        step;
        chk("cnt_1023", 32'(full_counter_o), 32'd1);
        step;
        chk("cnt_sat", 32'(full_counter_o), 32'd1);
        bvalid_i = 4'b0001;
        step;
        chk("cnt_incdec", 32'(full_counter_o), 32'd1);
        incr_req_i = 1'b0;
        step;
        chk("cnt_dec_full", 32'(full_counter_o), 32'd0);
        chk("cnt_dec_out", 32'(outstanding_trans_o), 32'd1);
        repeat (1022) step;
        chk("cnt_drain", 32'(outstanding_trans_o), 32'd0);
        step;
        bvalid_i = 4'b0000;
        chk("cnt_floor", 32'(outstanding_trans_o), 32'd0);
        incr_req_i = 1'b1;
        step;
        incr_req_i = 1'b0;
        chk("cnt_one_out", 32'(outstanding_trans_o), 32'd1);
        chk("cnt_one_full", 32'(full_counter_o), 32'd0);
        bvalid_i = 4'b0001;
        step;
        bvalid_i = 4'b0000;
        chk("cnt_zero", 32'(outstanding_trans_o), 32'd0);

        // DECERR waits for two outstanding responses
        incr_req_i = 1'b1;
        step;
        step;
        incr_req_i = 1'b0;
        err_push_i = 1'b1;
        err_id_i   = 16'd5;
        err_user_i = 6'd3;
        step;
        err_push_i = 1'b0;
        chk("err_pend", 32'(err_pending_o), 32'd1);
        chk("err_wait0", 32'(bvalid_o), 32'd0);
        step;
        chk("err_wait1", 32'(bvalid_o), 32'd0);
        bvalid_i = 4'b0001;
        step;
        bvalid_i = 4'b0000;
        #1;
        chk("err_cnt1", 32'(outstanding_trans_o), 32'd1);
        chk("err_wait2", 32'(bvalid_o), 32'd0);
        bvalid_i = 4'b0001;
        step;
        bvalid_i = 4'b0000;
        bready_i = 1'b0;
        #1;
        chk("err_wait3", 32'(bvalid_o), 32'd0);
        step;
        chk("err_valid", 32'(bvalid_o), 32'd1);
        chk("err_resp", 32'(bresp_o), 32'd3);
        chk("err_id", 32'(bid_o), 32'd5);
        chk("err_user", 32'(buser_o), 32'd3);
        chk("err_bready", 32'(bready_o), 32'd0);
        chk("err_cnt", 32'(outstanding_trans_o), 32'd0);
        bready_i = 1'b1;
        step;
        chk("err_popped", 32'(err_pending_o), 32'd0);
        chk("err_idle", 32'(bvalid_o), 32'd0);
        chk("err_cnt_keep", 32'(outstanding_trans_o), 32'd0);

        // FIFO fill, overflow drop, in-order drain
        incr_req_i = 1'b1;
        step;
        incr_req_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            err_push_i = 1'b1;
            err_id_i   = 16'(10 + i);
            err_user_i = 6'(1 + i);
            step;
            if (i == 3) chk("fifo_full", 32'(err_full_o), 32'd1);
        end
        err_push_i = 1'b0;
        chk("fifo_full5", 32'(err_full_o), 32'd1);
        chk("fifo_no_issue", 32'(bvalid_o), 32'd0);
        bvalid_i = 4'b0001;
        step;
        bvalid_i = 4'b0000;
        n_err = 0;
        for (int c = 0; c < 24; c++) begin
            if (bvalid_o && bresp_o == 2'b11) begin
                if (n_err < 8) begin
                    err_ids[n_err] = bid_o;
                    err_usr[n_err] = buser_o;
                end
                n_err++;
            end
            step;
        end
        chk("fifo_count", 32'(n_err), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("fifo_id", 32'(err_ids[i]), 32'(10 + i));
            chk("fifo_user", 32'(err_usr[i]), 32'(1 + i));
        end
        chk("fifo_empty", 32'(err_pending_o), 32'd0);

        // reset in the middle of a stalled transfer with queued error
        bvalid_i   = 4'b1111;
        bready_i   = 1'b0;
        incr_req_i = 1'b1;
        err_push_i = 1'b1;
        step;
        incr_req_i = 1'b0;
        err_push_i = 1'b0;
        chk("pre_rst_pend", 32'(err_pending_o), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mrst_bvalid", 32'(bvalid_o), 32'd0);
        chk("mrst_bready", 32'(bready_o), 32'd0);
        chk("mrst_bid", 32'(bid_o), 32'd0);
        chk("mrst_bresp", 32'(bresp_o), 32'd0);
        chk("mrst_buser", 32'(buser_o), 32'd0);
        chk("mrst_full", 32'(full_counter_o), 32'd0);
        chk("mrst_outst", 32'(outstanding_trans_o), 32'd0);
        chk("mrst_pend", 32'(err_pending_o), 32'd0);
        chk("mrst_efull", 32'(err_full_o), 32'd0);
        bvalid_i = 4'b0000;
        step;
        rst_n = 1'b1;
        step;
        chk("post_rst_pend", 32'(err_pending_o), 32'd0);
        chk("post_rst_out", 32'(outstanding_trans_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
